// File: rtl/apb_reg_bank_if.sv
// apb_reg_bank_if: APB bus signals between a master and the register bank slave
interface apb_reg_bank_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_W-1:0]     paddr;
   logic [DATA_W-1:0]     pwdata;
   logic [DATA_W/8-1:0]   pstrb;
   logic [DATA_W-1:0]     prdata;
   logic                  pready;
   logic                  pslverr;
   modport master (output psel, penable, pwrite, paddr, pwdata, pstrb, input prdata, pready, pslverr);
   modport slave (input psel, penable, pwrite, paddr, pwdata, pstrb, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_reg_bank.sv
// apb_reg_bank: APB slave register bank with wait states, byte strobes and read-only status slots
module apb_reg_bank #(
   parameter int                    DATA_W      = 32,
   parameter int                    NUM_REGS    = 8,
   parameter int                    ADDR_W      = 8,
   parameter int                    WAIT_CYCLES = 0,
   parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
) (
   input  logic                         pclk_i,
   input  logic                         preset_n_i,
   apb_reg_bank_if.slave                apb,
   input  logic [NUM_REGS*DATA_W-1:0]   hw_in_i,
   output logic [NUM_REGS*DATA_W-1:0]   reg_out_o
);
   localparam int NB = DATA_W / 8;
   logic [5:0]          cnt_q, cnt_d;
   logic [NUM_REGS-1:0] sel;
   logic                access, hit, ro_hit, err, we;
   logic [DATA_W-1:0]   rdata;
   logic                unused_hw;
   assign access      = apb.psel && apb.penable;
   assign apb.pready  = access && cnt_q == 6'(WAIT_CYCLES);
   assign cnt_d       = (!access || apb.pready) ? 6'd0 : (cnt_q < 6'(WAIT_CYCLES)) ? cnt_q + 6'd1 : cnt_q;
   assign hit         = |sel;
   assign ro_hit      = |(sel & RO_MASK);
   assign err         = !hit || (apb.pwrite && ro_hit);
   assign we          = apb.pready && apb.pwrite && !err;
   assign apb.pslverr = apb.pready && err;
   assign apb.prdata  = (apb.pready && !apb.pwrite && !err) ? rdata : '0;
   // writable slots never look at their hw_in slice
   assign unused_hw   = ^hw_in_i;
   always_ff @(posedge pclk_i or negedge preset_n_i) begin
      if (!preset_n_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_REGS; i++) if (sel[i]) rdata = reg_out_o[i*DATA_W +: DATA_W];
   end
   for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      assign sel[r] = apb.paddr == ADDR_W'(r);
      if (RO_MASK[r]) begin : g_ro
         assign reg_out_o[r*DATA_W +: DATA_W] = hw_in_i[r*DATA_W +: DATA_W];
      end else begin : g_rw
         logic [DATA_W-1:0] data_q, data_d;
         always_comb begin
            data_d = data_q;
            for (int b = 0; b < NB; b++) if (we && sel[r] && apb.pstrb[b]) data_d[8*b +: 8] = apb.pwdata[8*b +: 8];
         end
         always_ff @(posedge pclk_i or negedge preset_n_i) begin
            if (!preset_n_i) data_q <= '0;
            else data_q <= data_d;
         end
         assign reg_out_o[r*DATA_W +: DATA_W] = data_q;
      end
   end
endmodule

// File: tb/tb_apb_reg_bank.sv
// tb_apb_reg_bank: directed checks of apb_reg_bank with WAIT_CYCLES=2 and register 7 read-only
module tb_apb_reg_bank;
   logic          pclk = 1'b0;
   logic          preset_n;
   logic [255:0]  hw_in;
   logic [255:0]  reg_out;
   logic [31:0]   m [8];
   int            checks = 0;
   int            errors = 0;
   apb_reg_bank_if #(.ADDR_W(8), .DATA_W(32)) bus ();
   apb_reg_bank #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(8), .WAIT_CYCLES(2), .RO_MASK(8'h80)) dut (
      .pclk_i(pclk), .preset_n_i(preset_n), .apb(bus.slave), .hw_in_i(hw_in), .reg_out_o(reg_out));
   always #5 pclk = ~pclk;
   function automatic logic [255:0] model_vec();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = m[i];
      return v;
   endfunction
   // one transfer starting with its setup cycle now; n = wait cycles before pready, z = stray output seen
   task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                       output int n, output logic e, output logic [31:0] rd, output logic z);
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d; bus.pstrb = s;
      #1;
      z = bus.pready !== 1'b0 || bus.prdata !== 32'h0 || bus.pslverr !== 1'b0;
      @(posedge pclk); #1 bus.penable = 1'b1; #1;
      n = 0;
      while (bus.pready !== 1'b1 && n < 16) begin
         z |= bus.prdata !== 32'h0 || bus.pslverr !== 1'b0;
         @(posedge pclk); #2;
         n++;
      end
      e = bus.pslverr; rd = bus.prdata;
      @(posedge pclk); #1 bus.psel = 1'b0; bus.penable = 1'b0;
   endtask
   task automatic test_reset();
      int n; logic e, z; logic [31:0] rd;
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 8'd3; bus.pwdata = 32'h12345678; bus.pstrb = 4'hF;
      @(posedge pclk); #1 bus.penable = 1'b1;
      @(posedge pclk); #1 preset_n = 1'b0; #1;
      checks++; if (bus.pready !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b want 0", bus.pready); end
      checks++; if (bus.pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr: got %b want 0", bus.pslverr); end
      checks++; if (bus.prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h want 0", bus.prdata); end
      @(posedge pclk); @(posedge pclk); #1 bus.psel = 1'b0; bus.penable = 1'b0; preset_n = 1'b1; #1;
      checks++; if (reg_out !== 256'h0) begin errors++; $display("FAIL reset_reg_out: got %h want 0", reg_out); end
      @(posedge pclk); #1;
      xfer(1'b0, 8'd3, 32'h0, 4'h0, n, e, rd, z);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_reg3: got %h want 0", rd); end
   endtask
   task automatic test_write_read();
      int n; logic e, z; logic [31:0] rd;
      xfer(1'b1, 8'd2, 32'hDEADBEEF, 4'hF, n, e, rd, z); m[2] = 32'hDEADBEEF;
      checks++; if (n !== 2) begin errors++; $display("FAIL wr_waits: got %0d want 2", n); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", e); end
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL wr_stray: got %b want 0", z); end
      checks++; if (reg_out !== model_vec()) begin errors++; $display("FAIL wr_reg_out: got %h want %h", reg_out, model_vec()); end
      xfer(1'b0, 8'd2, 32'h0, 4'h0, n, e, rd, z);
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL rd_stray: got %b want 0", z); end
      checks++; if (bus.prdata !== 32'h0) begin errors++; $display("FAIL rd_idle_prdata: got %h want 0", bus.prdata); end
   endtask
   task automatic test_strobes();
      int n; logic e, z; logic [31:0] rd;
      xfer(1'b1, 8'd2, 32'h11223344, 4'b0101, n, e, rd, z); m[2] = 32'hDE22BE44;
      xfer(1'b0, 8'd2, 32'h0, 4'h0, n, e, rd, z);
      checks++; if (rd !== 32'hDE22BE44) begin errors++; $display("FAIL strb_data: got %h want de22be44", rd); end
      xfer(1'b1, 8'd2, 32'hFFFFFFFF, 4'h0, n, e, rd, z);
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL strb0_err: got %b want 0", e); end
      checks++; if (reg_out !== model_vec()) begin errors++; $display("FAIL strb0_reg_out: got %h want %h", reg_out, model_vec()); end
   endtask
   task automatic test_errors();
      int n; logic e, z; logic [31:0] rd;
      xfer(1'b1, 8'd9, 32'hFFFFFFFF, 4'hF, n, e, rd, z);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL wr_bad_addr_err: got %b want 1", e); end
      checks++; if (n !== 2) begin errors++; $display("FAIL wr_bad_addr_waits: got %0d want 2", n); end
      checks++; if (reg_out !== model_vec()) begin errors++; $display("FAIL wr_bad_addr_reg_out: got %h want %h", reg_out, model_vec()); end
      xfer(1'b0, 8'd8, 32'h0, 4'h0, n, e, rd, z);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL rd_bad_addr_err: got %b want 1", e); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rd_bad_addr_data: got %h want 0", rd); end
      hw_in[7*32 +: 32] = 32'hCAFE0001; m[7] = 32'hCAFE0001;
      xfer(1'b1, 8'd7, 32'h55555555, 4'hF, n, e, rd, z);
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL wr_ro_err: got %b want 1", e); end
      checks++; if (reg_out !== model_vec()) begin errors++; $display("FAIL wr_ro_reg_out: got %h want %h", reg_out, model_vec()); end
      xfer(1'b0, 8'd7, 32'h0, 4'h0, n, e, rd, z);
      checks++; if (rd !== 32'hCAFE0001) begin errors++; $display("FAIL rd_ro_data: got %h want cafe0001", rd); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd_ro_err: got %b want 0", e); end
   endtask
   task automatic test_abort();
      int n; logic e, z; logic [31:0] rd;
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 8'd4; bus.pwdata = 32'hA5A5A5A5; bus.pstrb = 4'hF;
      @(posedge pclk); #1 bus.penable = 1'b1; #1;
      checks++; if (bus.pready !== 1'b0) begin errors++; $display("FAIL abort_pready_access: got %b want 0", bus.pready); end
      @(posedge pclk); #1 bus.psel = 1'b0; #1;
      checks++; if (bus.pready !== 1'b0) begin errors++; $display("FAIL abort_pready_drop: got %b want 0", bus.pready); end
      @(posedge pclk); #1 bus.penable = 1'b0;
      checks++; if (reg_out !== model_vec()) begin errors++; $display("FAIL abort_reg_out: got %h want %h", reg_out, model_vec()); end
      xfer(1'b0, 8'd4, 32'h0, 4'h0, n, e, rd, z);
      checks++; if (n !== 2) begin errors++; $display("FAIL abort_next_waits: got %0d want 2", n); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_reg4: got %h want 0", rd); end
   endtask
   task automatic test_back_to_back();
      int n1, n2; logic e, z; logic [31:0] rd1, rd2;
      xfer(1'b0, 8'd2, 32'h0, 4'h0, n1, e, rd1, z);
      xfer(1'b0, 8'd7, 32'h0, 4'h0, n2, e, rd2, z);
      checks++; if (n1 !== 2) begin errors++; $display("FAIL b2b_waits_1: got %0d want 2", n1); end
      checks++; if (n2 !== 2) begin errors++; $display("FAIL b2b_waits_2: got %0d want 2", n2); end
      checks++; if (rd1 !== 32'hDE22BE44) begin errors++; $display("FAIL b2b_data_1: got %h want de22be44", rd1); end
      checks++; if (rd2 !== 32'hCAFE0001) begin errors++; $display("FAIL b2b_data_2: got %h want cafe0001", rd2); end
      xfer(1'b1, 8'd5, 32'h0BADF00D, 4'hF, n1, e, rd1, z); m[5] = 32'h0BADF00D;
      xfer(1'b0, 8'd5, 32'h0, 4'h0, n2, e, rd2, z);
      checks++; if (rd2 !== 32'h0BADF00D) begin errors++; $display("FAIL wr_then_rd: got %h want 0badf00d", rd2); end
      checks++; if (reg_out !== model_vec()) begin errors++; $display("FAIL final_reg_out: got %h want %h", reg_out, model_vec()); end
   endtask
   initial begin
      for (int i = 0; i < 8; i++) m[i] = 32'h0;
      preset_n = 1'b0; hw_in = '0;
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
      @(posedge pclk); @(posedge pclk); #1 preset_n = 1'b1;
      @(posedge pclk); #1;
      test_reset();
      test_write_read();
      test_strobes();
      test_errors();
      test_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
